// File: rtl/stack_ctrl.sv
// Stack memory, occupancy count and core/debug arbitration for the stack machine.
// Optional synchronous clear port enabled by defining STACK_CLEAR_EN.
module stack_ctrl #(
    parameter int REG_BITS     = 32,
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef STACK_CLEAR_EN
    input  logic                clear,
`endif
    input  logic [1:0]          core_op,
    input  logic [REG_BITS-1:0] core_wdata,
    output logic [REG_BITS-1:0] core_top,
    output logic [REG_BITS-1:0] core_next,
    output logic                core_stall,
    output logic [AW:0]         count,
    output logic                full,
    output logic                empty,
    output logic                ovf_err,
    output logic                unf_err,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [AW:0]         dbg_addr,
    input  logic [REG_BITS-1:0] dbg_wdata,
    output logic                dbg_gnt,
    output logic [REG_BITS-1:0] dbg_rdata,
    output logic                dbg_rvalid
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C = (AW+1)'(1);
    localparam logic [AW:0] TWO_C = (AW+1)'(2);
    localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_BINOP = 2'b11;

    logic [REG_BITS-1:0] mem [DEPTH];
    logic [AW:0]         cnt;
    logic [WW-1:0]       wait_cnt;
    logic                force_gnt;
    logic                gnt;
    logic                clr;
    logic [AW-1:0]       top_idx;
    logic [AW-1:0]       next_idx;
    logic                dbg_in;
    logic [AW-1:0]       dbg_idx;
    logic                core_we;
    logic [AW-1:0]       core_wa;
    logic [AW:0]         cnt_nxt;
    logic                ovf_set;
    logic                unf_set;

`ifdef STACK_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    assign count    = cnt;
    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign top_idx  = cnt[AW-1:0] - AW'(1);
    assign next_idx = cnt[AW-1:0] - AW'(2);

    assign core_top  = empty ? '0 : mem[top_idx];
    assign core_next = (cnt < TWO_C) ? '0 : mem[next_idx];

    // A starved request wins outright; otherwise debug only takes idle slots.
    assign force_gnt  = dbg_req && (wait_cnt == LIMIT_C);
    assign gnt        = dbg_req && (force_gnt || core_op == OP_NONE);
    assign dbg_gnt    = gnt;
    assign core_stall = force_gnt;

    assign dbg_in  = (dbg_addr < DEPTH_C);
    assign dbg_idx = dbg_addr[AW-1:0];

    always_comb begin
        core_we = 1'b0;
        core_wa = '0;
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!gnt && !clr) begin
            unique case (core_op)
                OP_PUSH: begin
                    if (!full) begin
                        core_we = 1'b1;
                        core_wa = cnt[AW-1:0];
                        cnt_nxt = cnt + ONE_C;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty) cnt_nxt = cnt - ONE_C;
                    else        unf_set = 1'b1;
                end
                OP_BINOP: begin
                    if (cnt >= TWO_C) begin
                        core_we = 1'b1;
                        core_wa = next_idx;
                        cnt_nxt = cnt - ONE_C;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (core_we)
            mem[core_wa] <= core_wdata;
        else if (gnt && dbg_we && dbg_in)
            mem[dbg_idx] <= dbg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            wait_cnt   <= '0;
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            if (clr) begin
                cnt     <= '0;
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                ovf_err <= ovf_err | ovf_set;
                unf_err <= unf_err | unf_set;
            end
            if (!dbg_req || gnt)
                wait_cnt <= '0;
            else if (wait_cnt != LIMIT_C)
                wait_cnt <= wait_cnt + WW'(1);
            dbg_rvalid <= gnt && !dbg_we;
            if (gnt && !dbg_we)
                dbg_rdata <= dbg_in ? mem[dbg_idx] : '0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized and directed bench for stack_ctrl against a behavioural stack model.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  core_op = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_top, core_next;
    logic        core_stall;
    logic [4:0]  count;
    logic        full, empty, ovf_err, unf_err;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
`ifdef STACK_CLEAR_EN
    logic        clear = 1'b0;
`endif

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STACK_CLEAR_EN
        .clear(clear),
`endif
        .core_op(core_op), .core_wdata(core_wdata),
        .core_top(core_top), .core_next(core_next),
        .core_stall(core_stall), .count(count),
        .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain array with an occupancy count.
    logic [31:0] mm [16];
    int          mc = 0;
    bit          movf = 0, munf = 0;
    int          mwait = 0;
    logic [31:0] mrd = '0;
    bit          mrv = 0;
    bit          mg, ms;

    task automatic cyc(input logic [1:0] op, input logic [31:0] wd,
                       input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] dw, input logic cl);
        core_op = op; core_wdata = wd;
        dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = dw;
`ifdef STACK_CLEAR_EN
        clear = cl;
`endif
        #1;
        ms = r && (mwait == 4);
        mg = r && (ms || op == 2'b00);
        check("gnt", dbg_gnt, mg);
        check("stall", core_stall, ms);
        check("top", core_top, (mc == 0) ? 0 : mm[mc-1]);
        check("next", core_next, (mc < 2) ? 0 : mm[mc-2]);
        check("count", count, mc);
        check("full", full, mc == 16);
        check("empty", empty, mc == 0);
        check("ovf", ovf_err, movf);
        check("unf", unf_err, munf);
        check("rvalid", dbg_rvalid, mrv);
        check("rdata", dbg_rdata, mrd);
        @(posedge clk);
        mrv = 0;
        if (mg) begin
            if (w) begin
                if (a < 16) mm[a] = dw;
            end else begin
                mrd = (a < 16) ? mm[a] : 0;
                mrv = 1;
            end
        end
        if (cl) begin
            mc = 0; movf = 0; munf = 0;
        end else if (!mg) begin
            case (op)
                2'b01: if (mc < 16) begin mm[mc] = wd; mc++; end
                       else movf = 1;
                2'b10: if (mc > 0) mc--; else munf = 1;
                2'b11: if (mc >= 2) begin mm[mc-2] = wd; mc--; end
                       else munf = 1;
                default: ;
            endcase
        end
        if (!r || mg) mwait = 0;
        else if (mwait < 4) mwait++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rvalid", dbg_rvalid, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_unf", unf_err, 0);
        mc = 0; movf = 0; munf = 0; mwait = 0; mrd = '0; mrv = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int seen;
        bit pr, pw;
        logic [4:0] pa;
        logic [31:0] pd;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc(2'b00, 0, 1, 1, 5'(i), $urandom, 0);

        cyc(2'b00, 0, 1, 1, 5'd0, 3, 0);
        cyc(2'b00, 0, 1, 1, 5'd1, 3, 0);
        cyc(2'b01, 3, 0, 0, 0, 0, 0);
        cyc(2'b01, 3, 0, 0, 0, 0, 0);
        check("tp_count2", count, 2);
        check("tp_top3", core_top, 3);
        check("tp_next3", core_next, 3);

        cyc(2'b11, 6, 0, 0, 0, 0, 0);
        check("tp_binop_count", count, 1);
        check("tp_binop_top", core_top, 6);
        check("tp_binop_next", core_next, 0);
        check("tp_binop_unf", unf_err, 0);

        cyc(2'b10, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++)
            cyc(2'b01, 100 + i, 0, 0, 0, 0, 0);
        check("tp_full_count", count, 16);
        check("tp_full", full, 1);
        check("tp_ovf", ovf_err, 1);
        cyc(2'b00, 0, 1, 0, 5'd15, 0, 0);
        check("tp_mem15_rvalid", dbg_rvalid, 1);
        check("tp_mem15", dbg_rdata, 115);

        do_reset();
        cyc(2'b10, 0, 0, 0, 0, 0, 0);
        check("tp_pop_empty_unf", unf_err, 1);
        check("tp_pop_empty_count", count, 0);

        do_reset();
        cyc(2'b01, 7, 0, 0, 0, 0, 0);
        cyc(2'b11, 9, 0, 0, 0, 0, 0);
        check("tp_binop1_count", count, 1);
        check("tp_binop1_top", core_top, 7);
        check("tp_binop1_unf", unf_err, 1);

        do_reset();
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(2'b01, 200 + k, 1, 0, 5'd0, 0, 0);
            if (mg) begin
                seen = k;
                break;
            end
        end
        check("starve_cycle", seen, 5);
        check("starve_count", count, 4);
        check("starve_rvalid", dbg_rvalid, 1);
        check("starve_rdata", dbg_rdata, 201);

        cyc(2'b00, 0, 1, 0, 5'd16, 0, 0);
        check("oob_rvalid", dbg_rvalid, 1);
        check("oob_rdata", dbg_rdata, 0);

        cyc(2'b00, 0, 1, 0, 5'd0, 0, 0);
        do_reset();

`ifdef STACK_CLEAR_EN
        cyc(2'b10, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(2'b01, 300 + i, 0, 0, 0, 0, 0);
        cyc(2'b01, 999, 0, 0, 0, 0, 1);
        check("clr_count", count, 0);
        check("clr_unf", unf_err, 0);
        check("clr_ovf", ovf_err, 0);
`endif

        pr = 0; pw = 0; pa = '0; pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pr && $urandom_range(0, 3) == 0) begin
                pr = 1;
                pw = 1'($urandom_range(0, 1));
                pa = 5'($urandom_range(0, 16));
                pd = $urandom;
            end
            cyc(2'($urandom_range(0, 3)), $urandom, pr, pw, pa, pd, 0);
            if (mg) pr = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
